// File: rtl/fg_prog_pkg.sv
// -----------------------------------------------------------------------------
// fg_prog_pkg
// Types and constants shared by the floating-gate programming sequencer.
//   state_t    : sequencer phases
//   GORS_*     : GorS switch select encodings
//   prog_cmd_t : one latched programming command
// The command field widths come from the FG_* localparams below. The
// sequencer's width parameters default to these values and must stay equal
// to them.
// -----------------------------------------------------------------------------
package fg_prog_pkg;

  localparam int FG_ISLAND_W = 2;
  localparam int FG_ROW_W    = 4;
  localparam int FG_COL_W    = 4;
  localparam int FG_PW_W     = 12;
  localparam int FG_NP_W     = 8;

  // GorS switch: route HV to the gate (injection) or to the source (tunnelling)
  localparam logic GORS_GATE   = 1'b0;
  localparam logic GORS_SOURCE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_GAP,
    ST_DISCHARGE,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [FG_ISLAND_W-1:0] island;
    logic [FG_ROW_W-1:0]    row;
    logic [FG_COL_W-1:0]    col;
    logic                   mode;
    logic [FG_NP_W-1:0]     npulse;
    logic [FG_PW_W-1:0]     width;
  } prog_cmd_t;

  // A zero pulse width still produces a single-cycle pulse
  function automatic logic [FG_PW_W-1:0] eff_width(input logic [FG_PW_W-1:0] w);
    return (w == '0) ? FG_PW_W'(1) : w;
  endfunction

endpackage

// File: rtl/fg_phase_timer.sv
// -----------------------------------------------------------------------------
// fg_phase_timer
// Loadable down-counter shared by the settle/gap/discharge and pulse-width
// phases. Loading L gives a phase of exactly L cycles: the count walks
// L, L-1, ..., 1 and then parks at 1, so no phase relies on wrap-around.
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val on the next edge (wins over counting)
//   load_val   : phase length in cycles (>= 1)
//   last       : high during the final cycle of the current phase
// -----------------------------------------------------------------------------
module fg_phase_timer #(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: clocked state uses non-blocking (<=) so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q > CNT_W'(1)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/fg_prog_sequencer.sv
// -----------------------------------------------------------------------------
// fg_prog_sequencer
// Sequences floating-gate programming of one indirect switch cell. One
// command selects island/row/column, GorS mode, pulse count and pulse width.
// The sequencer then steps SETUP -> (PULSE -> GAP)* -> DISCHARGE -> DONE.
// Every output is registered. The selects only load on accept, while
// mux_en is low.
//   cmd_valid/cmd_ready        : command handshake (ready only in IDLE)
//   cmd_island/row/col/mode    : target cell and injection/tunnelling mode
//   cmd_npulse, cmd_width      : pulse count (0 = dry run), cycles per pulse
//   abort                      : cut SETUP/PULSE/GAP short, go to DISCHARGE
//   island_sel/row_sel/col_sel : registered mux selects
//   gors_sel                   : GorS switch select
//   mux_en, pulse_hv           : programming mux enable, HV pulse enable
//   busy, done, aborted        : status; done is a one-cycle strobe
//   pulses_done                : complete pulses for current/last command
// -----------------------------------------------------------------------------
module fg_prog_sequencer
  import fg_prog_pkg::*;
#(
  parameter int ISLAND_W = FG_ISLAND_W,
  parameter int ROW_W    = FG_ROW_W,
  parameter int COL_W    = FG_COL_W,
  parameter int PW_W     = FG_PW_W,
  parameter int NP_W     = FG_NP_W,
  parameter int SETTLE   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ISLAND_W-1:0] cmd_island,
  input  logic [ROW_W-1:0]    cmd_row,
  input  logic [COL_W-1:0]    cmd_col,
  input  logic                cmd_mode,
  input  logic [NP_W-1:0]     cmd_npulse,
  input  logic [PW_W-1:0]     cmd_width,
  input  logic                abort,
  output logic [ISLAND_W-1:0] island_sel,
  output logic [ROW_W-1:0]    row_sel,
  output logic [COL_W-1:0]    col_sel,
  output logic                gors_sel,
  output logic                mux_en,
  output logic                pulse_hv,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [NP_W-1:0]     pulses_done
);

  localparam int SETTLE_W = $clog2(SETTLE + 1);
  localparam int TMR_W    = (PW_W > SETTLE_W) ? PW_W : SETTLE_W;

  state_t     state_q, state_d;
  prog_cmd_t  cmd_q, cmd_d;
  logic [NP_W-1:0]  pulses_d, pulses_inc;
  logic             aborted_d;
  logic             tmr_load, tmr_last;
  logic [TMR_W-1:0] tmr_val, settle_val, width_val;

  assign settle_val = TMR_W'(SETTLE);
  assign width_val  = TMR_W'(eff_width(cmd_q.width));
  assign pulses_inc = pulses_done + NP_W'(1);

  fg_phase_timer #(
    .CNT_W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .last     (tmr_last)
  );

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    pulses_d  = pulses_done;
    aborted_d = aborted;
    tmr_load  = 1'b0;
    tmr_val   = settle_val;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cmd_d     = '{island: cmd_island, row: cmd_row, col: cmd_col,
                        mode: cmd_mode, npulse: cmd_npulse, width: cmd_width};
          pulses_d  = '0;
          aborted_d = 1'b0;
          tmr_load  = 1'b1;
          state_d   = ST_SETUP;
        end
      end

      ST_SETUP, ST_GAP: begin
        if (abort) begin
          aborted_d = 1'b1;
          tmr_load  = 1'b1;
          state_d   = ST_DISCHARGE;
        end else if (tmr_last) begin
          tmr_load = 1'b1;
          if (cmd_q.npulse == '0) begin
            state_d = ST_DISCHARGE;
          end else begin
            tmr_val = width_val;
            state_d = ST_PULSE;
          end
        end
      end

      ST_PULSE: begin
        // A pulse cut short by abort is not counted.
        if (abort) begin
          aborted_d = 1'b1;
          tmr_load  = 1'b1;
          state_d   = ST_DISCHARGE;
        end else if (tmr_last) begin
          pulses_d = pulses_inc;
          tmr_load = 1'b1;
          state_d  = (pulses_inc == cmd_q.npulse) ? ST_DISCHARGE : ST_GAP;
        end
      end

      ST_DISCHARGE: begin
        if (tmr_last) state_d = ST_DONE;
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so they line up with the phase.
  // NOTE: the async reset drops pulse_hv/mux_en at once, even with clk stopped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      pulses_done <= '0;
      aborted     <= 1'b0;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      mux_en      <= 1'b0;
      pulse_hv    <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      pulses_done <= pulses_d;
      aborted     <= aborted_d;
      cmd_ready   <= (state_d == ST_IDLE);
      busy        <= (state_d != ST_IDLE);
      mux_en      <= (state_d inside {ST_SETUP, ST_PULSE, ST_GAP, ST_DISCHARGE});
      pulse_hv    <= (state_d == ST_PULSE);
      done        <= (state_d == ST_DONE);
    end
  end

  assign island_sel = cmd_q.island;
  assign row_sel    = cmd_q.row;
  assign col_sel    = cmd_q.col;
  assign gors_sel   = cmd_q.mode ? GORS_SOURCE : GORS_GATE;

endmodule

// File: tb/tb_fg_prog_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fg_prog_sequencer
// Directed and randomized commands against a phase-timeline reference model.
// The model lays out the expected phase of every cycle after accept: SETTLE
// setup cycles, then pulses and gaps, then SETTLE discharge cycles and one done
// cycle. An abort truncates that timeline.
// -----------------------------------------------------------------------------
module tb_fg_prog_sequencer;

  localparam int S = 4;

  logic       clk, rst_n;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_island;
  logic [3:0] cmd_row, cmd_col;
  logic       cmd_mode;
  logic [7:0] cmd_npulse;
  logic [11:0] cmd_width;
  logic       abort;
  logic [1:0] island_sel;
  logic [3:0] row_sel, col_sel;
  logic       gors_sel, mux_en, pulse_hv, busy, done, aborted;
  logic [7:0] pulses_done;

  fg_prog_sequencer #(.SETTLE(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_island  (cmd_island),
    .cmd_row     (cmd_row),
    .cmd_col     (cmd_col),
    .cmd_mode    (cmd_mode),
    .cmd_npulse  (cmd_npulse),
    .cmd_width   (cmd_width),
    .abort       (abort),
    .island_sel  (island_sel),
    .row_sel     (row_sel),
    .col_sel     (col_sel),
    .gors_sel    (gors_sel),
    .mux_en      (mux_en),
    .pulse_hv    (pulse_hv),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .pulses_done (pulses_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef enum {P_SETUP, P_PULSE, P_GAP, P_DIS, P_DONE} ph_t;
  typedef struct {
    ph_t ph;
    int  pulses;
  } smp_t;

  smp_t exp_q[$];
  bit   exp_aborted;
  int   last_done_idx;

  // Back-to-back support: keep cmd_valid high and offer the next command
  bit         hold_valid = 1'b0;
  logic [1:0] nxt_island;
  logic [3:0] nxt_row, nxt_col;
  logic       nxt_mode;
  logic [7:0] nxt_np;
  logic [11:0] nxt_w;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push_n(ph_t ph, int n, int c);
    smp_t s;
    s.ph     = ph;
    s.pulses = c;
    for (int i = 0; i < n; i++) exp_q.push_back(s);
  endfunction

  // Expected per-cycle timeline, one entry per cycle after the accept edge
  function automatic void build_model(int np, int w, int abort_at);
    int we = (w == 0) ? 1 : w;
    int c  = 0;
    exp_q.delete();
    exp_aborted = 1'b0;
    push_n(P_SETUP, S, 0);
    for (int p = 0; p < np; p++) begin
      push_n(P_PULSE, we, c);
      c++;
      if (p < np - 1) push_n(P_GAP, S, c);
    end
    push_n(P_DIS, S, c);
    push_n(P_DONE, 1, c);
    if (abort_at >= 0 && abort_at < exp_q.size() &&
        exp_q[abort_at].ph inside {P_SETUP, P_PULSE, P_GAP}) begin
      c = exp_q[abort_at].pulses;
      while (exp_q.size() > abort_at + 1) void'(exp_q.pop_back());
      push_n(P_DIS, S, c);
      push_n(P_DONE, 1, c);
      exp_aborted = 1'b1;
    end
  endfunction

  // Called at a negedge with the DUT idle; returns at the idle cycle after done
  task automatic run_cmd(input int isl, input int row, input int col, input int mode,
                         input int np, input int w, input int abort_at);
    int fin;
    build_model(np, w, abort_at);
    check("pre_ready", 32'(cmd_ready), 1);
    cmd_island = 2'(isl); cmd_row = 4'(row); cmd_col = 4'(col);
    cmd_mode = 1'(mode); cmd_npulse = 8'(np); cmd_width = 12'(w);
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (hold_valid) begin
      cmd_island = nxt_island; cmd_row = nxt_row; cmd_col = nxt_col;
      cmd_mode = nxt_mode; cmd_npulse = nxt_np; cmd_width = nxt_w;
    end else begin
      cmd_valid = 1'b0;
    end
    last_done_idx = -1;
    for (int j = 0; j < exp_q.size(); j++) begin
      check($sformatf("mux_en[%0d]", j),   32'(mux_en),   32'(exp_q[j].ph != P_DONE));
      check($sformatf("pulse_hv[%0d]", j), 32'(pulse_hv), 32'(exp_q[j].ph == P_PULSE));
      check($sformatf("done[%0d]", j),     32'(done),     32'(exp_q[j].ph == P_DONE));
      check($sformatf("busy[%0d]", j),     32'(busy),     1);
      check($sformatf("ready[%0d]", j),    32'(cmd_ready), 0);
      check($sformatf("pdone[%0d]", j),    32'(pulses_done), 32'(exp_q[j].pulses));
      check($sformatf("sel[%0d]", j), {19'd0, island_sel, row_sel, col_sel, gors_sel},
            {19'd0, 2'(isl), 4'(row), 4'(col), 1'(mode)});
      if (done === 1'b1 && last_done_idx < 0) last_done_idx = j;
      if (exp_q[j].ph == P_DONE) check("aborted_at_done", 32'(aborted), 32'(exp_aborted));
      abort = (j == abort_at);
      @(negedge clk);
    end
    abort = 1'b0;
    fin = exp_q.size();
    check("idle_busy",  32'(busy), 0);
    check("idle_ready", 32'(cmd_ready), 1);
    check("idle_mux",   32'(mux_en), 0);
    check("idle_hv",    32'(pulse_hv), 0);
    check("idle_done",  32'(done), 0);
    check("idle_abrt",  32'(aborted), 32'(exp_aborted));
    check("idle_pdone", 32'(pulses_done), 32'(exp_q[fin-1].pulses));
    check("idle_sel", {19'd0, island_sel, row_sel, col_sel, gors_sel},
          {19'd0, 2'(isl), 4'(row), 4'(col), 1'(mode)});
    check("latency_idx", 32'(last_done_idx), 32'(fin - 1));
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; abort = 1'b0;
    cmd_island = '0; cmd_row = '0; cmd_col = '0; cmd_mode = 1'b0;
    cmd_npulse = '0; cmd_width = '0;
    #12;
    check("rst_ready", 32'(cmd_ready), 1);
    check("rst_outs", {23'd0, mux_en, pulse_hv, busy, done, aborted, gors_sel, 3'd0},
          32'd0);
    check("rst_sel_pd", {14'd0, island_sel, row_sel, col_sel, pulses_done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 0);

    // Two 3-cycle pulses: done in cycle 4+3+4+3+4+1 = 19 after accept
    run_cmd(1, 0, 1, 0, 2, 3, -1);
    check("lat_np2", 32'(last_done_idx + 1), 19);
    check("np2_pdone", 32'(pulses_done), 2);

    // Dry run, tunnelling: done in cycle 9
    run_cmd(2, 5, 9, 1, 0, 7, -1);
    check("lat_dry", 32'(last_done_idx + 1), 9);
    check("dry_gors", 32'(gors_sel), 1);

    // Width 0 acts as width 1
    run_cmd(3, 15, 15, 0, 1, 0, -1);
    check("lat_w0", 32'(last_done_idx + 1), 10);

    // Abort in the 2nd cycle of pulse 2: pulses 4..6, gap 7..10, pulse 2 at 11..
    run_cmd(0, 3, 7, 1, 5, 3, 12);
    check("abort_flag", 32'(aborted), 1);
    check("abort_pdone", 32'(pulses_done), 1);
    check("lat_abort", 32'(last_done_idx + 1), 18);

    // Abort during DISCHARGE is ignored
    run_cmd(1, 1, 1, 0, 1, 2, 7);
    check("dis_abort_ign", 32'(aborted), 0);

    // Abort while idle is ignored
    abort = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_abort_busy", 32'(busy), 0);
    end
    abort = 1'b0;

    // cmd_valid held high: second command is not latched early, then follows done
    hold_valid = 1'b1;
    nxt_island = 2'd2; nxt_row = 4'd8; nxt_col = 4'd4; nxt_mode = 1'b1;
    nxt_np = 8'd1; nxt_w = 12'd1;
    run_cmd(1, 2, 3, 0, 1, 2, -1);
    hold_valid = 1'b0;
    check("b2b_valid_held", 32'(cmd_valid), 1);
    run_cmd(2, 8, 4, 1, 1, 1, -1);

    // Reset mid-pulse: pulses occupy cycles 4..9 after accept
    cmd_island = 2'd3; cmd_row = 4'd6; cmd_col = 4'd2; cmd_mode = 1'b0;
    cmd_npulse = 8'd3; cmd_width = 12'd6; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (S + 1) @(negedge clk);
    check("rst_pre_hv", 32'(pulse_hv), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_hv",    32'(pulse_hv), 0);
    check("rst_mid_mux",   32'(mux_en), 0);
    check("rst_mid_busy",  32'(busy), 0);
    check("rst_mid_ready", 32'(cmd_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rel_ready", 32'(cmd_ready), 1);
    check("rst_rel_busy",  32'(busy), 0);
    run_cmd(0, 9, 12, 1, 1, 2, -1);

    // Randomized commands, about one in three with an abort at a random cycle
    for (int k = 0; k < 14; k++) begin
      int isl = int'($urandom_range(0, 3));
      int row = int'($urandom_range(0, 15));
      int col = int'($urandom_range(0, 15));
      int md  = int'($urandom_range(0, 1));
      int np  = int'($urandom_range(0, 4));
      int w   = int'($urandom_range(0, 5));
      int ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 40)) : -1;
      run_cmd(isl, row, col, md, np, w, ab);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
